// File: rtl/dmem_access_seq.sv
// Load/store sequencer between the core datapath and a variable-latency word-wide data memory port.
// Latency: aligned access completes 3 cycles after acceptance with grant/rvalid back to back; a split access adds at least 2.
// Backpressure: stall holds the core while an access is in flight; mem_req is held, stable, until mem_gnt.
// Optional: define DMEM_MISALIGN_SPLIT_EN to split misaligned accesses into two beats (otherwise they fault).
module dmem_access_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t state, state_nxt;

  // Captured request fields, valid from REQ0 until the next acceptance
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
`ifdef DMEM_MISALIGN_SPLIT_EN
  logic        split_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;   // raw first beat; its lanes off..3 are the low bytes of the result
`else
  logic        fault_q;
`endif

  logic [1:0]  off_in;
  logic        split_in;
  logic        issue0;
  logic [31:0] ld_word;

  // Access size in bytes; 2'b11 behaves as a word
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Unshifted lane mask covering the low nbytes lanes
  function automatic logic [3:0] low_lanes(input logic [1:0] sz);
    case (sz)
      2'b00:   low_lanes = 4'b0001;
      2'b01:   low_lanes = 4'b0011;
      default: low_lanes = 4'b1111;
    endcase
  endfunction

  // Sign- or zero-extend a right-justified load value
  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] sz, input logic sg);
    case (sz)
      2'b00:   load_ext = {{24{sg & d[7]}}, d[7:0]};
      2'b01:   load_ext = {{16{sg & d[15]}}, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  assign off_in   = req_addr[1:0];
  assign split_in = ({2'b00, off_in} + {1'b0, size_bytes(req_size)}) > 4'd4;

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign issue0  = (state == IDLE) && req_valid;
  assign ld_word = (state == RSP1) ? 32'({mem_rdata, merge_q} >> {off_q, 3'b000})
                                   : (mem_rdata >> {off_q, 3'b000});
`else
  assign issue0  = (state == IDLE) && req_valid && !split_in;
  assign ld_word = mem_rdata >> {off_q, 3'b000};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the unregistered handshake outputs
  always_comb begin
    state_nxt      = state;
    stall          = 1'b0;
    rsp_valid      = 1'b0;
    misalign_fault = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid & rst_n;
        if (req_valid) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
          state_nxt = REQ0;
`else
          state_nxt = split_in ? DONE : REQ0;
`endif
        end
      end
      REQ0: begin
        stall = 1'b1;
        if (mem_gnt) state_nxt = RSP0;
      end
      RSP0: begin
        stall = 1'b1;
        if (mem_rvalid) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
          state_nxt = split_q ? REQ1 : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
      REQ1: begin
        stall = 1'b1;
        if (mem_gnt) state_nxt = RSP1;
      end
      RSP1: begin
        stall = 1'b1;
        if (mem_rvalid) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
`ifndef DMEM_MISALIGN_SPLIT_EN
        misalign_fault = fault_q;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request, drive the registered memory port and merge load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
`ifdef DMEM_MISALIGN_SPLIT_EN
      split_q   <= 1'b0;
      wdata_q   <= 32'h0;
      merge_q   <= 32'h0;
`else
      fault_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        size_q   <= req_size;
        off_q    <= off_in;
`ifdef DMEM_MISALIGN_SPLIT_EN
        split_q  <= split_in;
        wdata_q  <= req_wdata;
`else
        fault_q  <= split_in;
`endif
      end
      if (issue0) begin
        mem_req   <= 1'b1;
        mem_we    <= req_we;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_be    <= low_lanes(req_size) << off_in;
        mem_wdata <= req_wdata << {off_in, 3'b000};
      end
      case (state)
        REQ0, REQ1: begin
          if (mem_gnt) mem_req <= 1'b0;
        end
        RSP0: begin
          if (mem_rvalid) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            merge_q <= mem_rdata;
            if (split_q) begin
              // Second beat: next word (wraps mod 2^32), lanes that spilled past lane 3
              mem_req   <= 1'b1;
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= 4'(({4'b0000, low_lanes(size_q)} << off_q) >> 4);
              mem_wdata <= 32'(({32'h0, wdata_q} << {off_q, 3'b000}) >> 32);
            end else if (!we_q) begin
              rsp_rdata <= load_ext(ld_word, size_q, signed_q);
            end
`else
            if (!we_q) rsp_rdata <= load_ext(ld_word, size_q, signed_q);
`endif
          end
        end
        RSP1: begin
          if (mem_rvalid && !we_q) rsp_rdata <= load_ext(ld_word, size_q, signed_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_seq.sv
// Directed bench for dmem_access_seq with a reactive memory model.
// Cycle 0 is the cycle req_valid is first presented; outputs are sampled on the falling edge.
// Inputs change 1ns after the rising edge.
module tb_dmem_access_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        stall, rsp_valid, misalign_fault;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  // memory model controls
  logic        mem_auto = 1'b1;
  int          gnt_delay = 0;
  logic        man_gnt = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        auto_gnt = 1'b0, auto_rvalid = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  logic        pend = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] rdq[$];
  logic [31:0] log_addr[$];
  logic [3:0]  log_be[$];
  logic [31:0] log_wd[$];
  logic        log_we[$];

  assign mem_gnt    = mem_auto ? auto_gnt    : man_gnt;
  assign mem_rvalid = mem_auto ? auto_rvalid : man_rvalid;
  assign mem_rdata  = mem_auto ? auto_rdata  : man_rdata;

  dmem_access_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_signed(req_signed),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .misalign_fault(misalign_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: grant after gnt_delay request cycles, read data / write ack the cycle after grant
  always @(posedge clk) begin
    #1;
    auto_gnt    = 1'b0;
    auto_rvalid = 1'b0;
    if (!mem_auto || !rst_n) begin
      pend     = 1'b0;
      wait_cnt = 0;
    end else begin
      if (pend) begin
        auto_rvalid = 1'b1;
        auto_rdata  = 32'h0;
        if (rdq.size() > 0) auto_rdata = rdq.pop_front();
        pend = 1'b0;
      end
      if (mem_req) begin
        if (wait_cnt >= gnt_delay) begin
          auto_gnt = 1'b1;
          pend     = 1'b1;
          wait_cnt = 0;
          log_addr.push_back(mem_addr);
          log_be.push_back(mem_be);
          log_wd.push_back(mem_wdata);
          log_we.push_back(mem_we);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_be.delete();
    log_wd.delete();
    log_we.delete();
  endtask

  // Present one request and measure it; called at posedge+1, returns at posedge+1
  task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg,
                         output int done_cyc, output int stall_cnt, output int req_cnt,
                         output logic fault);
    req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
    req_valid = 1'b1;
    done_cyc = -1; stall_cnt = 0; req_cnt = 0; fault = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (mem_req) req_cnt++;
      if (rsp_valid) begin
        done_cyc = c;
        fault    = misalign_fault;
        break;
      end
      @(posedge clk);
      #1;
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b10; req_signed = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({stall, rsp_valid, misalign_fault, mem_req, mem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: stall/rsp_valid/fault/mem_req/mem_we = %b, expected 00000",
               {stall, rsp_valid, misalign_fault, mem_req, mem_we});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h be=%b wdata=%h, expected all zero",
               rsp_rdata, mem_addr, mem_be, mem_wdata);
    end
    tick();
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw;
    int d, s, r; logic f;
    clear_log(); rdq.push_back(32'hDEADBEEF);
    run_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, d, s, r, f);
    checks++;
    if (d != 3 || s != 3) begin
      errors++; $display("FAIL lw_timing: done cycle %0d stalls %0d, expected 3 and 3", d, s);
    end
    checks++;
    if (rsp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data: got %h expected deadbeef", rsp_rdata);
    end
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h100 || log_be[0] !== 4'b1111 || log_we[0] !== 1'b0) begin
      errors++; $display("FAIL lw_beat: beats %0d addr %h be %b we %b, expected 1 beat 00000100 1111 0",
                         log_addr.size(), log_addr[0], log_be[0], log_we[0]);
    end
    // req_valid was still high during DONE; it must not start a second access
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL ignore_done: stall %b mem_req %b, expected 0 0", stall, mem_req);
    end
    tick();
  endtask

  task automatic test_lb;
    int d, s, r; logic f;
    clear_log(); rdq.push_back(32'h80123456);
    run_req(1'b0, 32'h203, 32'h0, 2'b00, 1'b1, d, s, r, f);
    checks++;
    if (rsp_rdata !== 32'hFFFFFF80 || log_be.size() != 1 || log_be[0] !== 4'b1000 || log_addr[0] !== 32'h200) begin
      errors++; $display("FAIL lb_signed: rdata %h be %b addr %h, expected ffffff80 1000 00000200",
                         rsp_rdata, log_be[0], log_addr[0]);
    end
    rdq.push_back(32'h80123456);
    run_req(1'b0, 32'h203, 32'h0, 2'b00, 1'b0, d, s, r, f);
    checks++;
    if (rsp_rdata !== 32'h00000080 || d != 3) begin
      errors++; $display("FAIL lbu: rdata %h done %0d, expected 00000080 3", rsp_rdata, d);
    end
  endtask

  task automatic test_sh;
    int d, s, r; logic f;
    clear_log(); rdq.push_back(32'h5555AAAA);
    run_req(1'b1, 32'h302, 32'h0000ABCD, 2'b01, 1'b0, d, s, r, f);
    checks++;
    if (log_be.size() != 1 || log_be[0] !== 4'b1100 || log_wd[0] !== 32'hABCD0000 ||
        log_we[0] !== 1'b1 || log_addr[0] !== 32'h300) begin
      errors++; $display("FAIL sh_beat: be %b wdata %h we %b addr %h, expected 1100 abcd0000 1 00000300",
                         log_be[0], log_wd[0], log_we[0], log_addr[0]);
    end
    checks++;
    if (d != 3 || f !== 1'b0 || rsp_rdata !== 32'h00000080) begin
      errors++; $display("FAIL sh_done: done %0d fault %b rdata %h, expected 3 0 00000080", d, f, rsp_rdata);
    end
  endtask

  task automatic test_lh;
    int d, s, r; logic f;
    clear_log(); rdq.push_back(32'h00F00D00);
    run_req(1'b0, 32'h401, 32'h0, 2'b01, 1'b0, d, s, r, f);
    checks++;
    if (rsp_rdata !== 32'h0000F00D || log_be[0] !== 4'b0110) begin
      errors++; $display("FAIL lhu_off1: rdata %h be %b, expected 0000f00d 0110", rsp_rdata, log_be[0]);
    end
    rdq.push_back(32'h00F00D00);
    run_req(1'b0, 32'h401, 32'h0, 2'b01, 1'b1, d, s, r, f);
    checks++;
    if (rsp_rdata !== 32'hFFFFF00D) begin
      errors++; $display("FAIL lh_off1: rdata %h, expected fffff00d", rsp_rdata);
    end
  endtask

  task automatic test_split;
    int d, s, r; logic f;
    clear_log(); rdq.push_back(32'h332211AA); rdq.push_back(32'hBBCCDD44);
    run_req(1'b0, 32'h1001, 32'h0, 2'b10, 1'b0, d, s, r, f);
`ifdef DMEM_MISALIGN_SPLIT_EN
    checks++;
    if (d != 5 || s != 5 || f !== 1'b0 || rsp_rdata !== 32'h44332211) begin
      errors++; $display("FAIL split_lw: done %0d stalls %0d fault %b rdata %h, expected 5 5 0 44332211",
                         d, s, f, rsp_rdata);
    end
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 32'h1000 || log_be[0] !== 4'b1110 ||
        log_addr[1] !== 32'h1004 || log_be[1] !== 4'b0001) begin
      errors++; $display("FAIL split_beats: n %0d %h/%b %h/%b, expected 2 00001000/1110 00001004/0001",
                         log_addr.size(), log_addr[0], log_be[0], log_addr[1], log_be[1]);
    end
`else
    checks++;
    if (d != 1 || f !== 1'b1 || r != 0 || s != 1 || rsp_rdata !== 32'hFFFFF00D) begin
      errors++; $display("FAIL misalign_lw: done %0d fault %b reqs %0d stalls %0d rdata %h, expected 1 1 0 1 fffff00d",
                         d, f, r, s, rsp_rdata);
    end
    checks++;
    if (log_addr.size() != 0) begin
      errors++; $display("FAIL misalign_noreq: %0d memory beats, expected 0", log_addr.size());
    end
    rdq.delete();
`endif
  endtask

  task automatic test_wrap;
    int d, s, r; logic f;
    clear_log(); rdq.push_back(32'h0); rdq.push_back(32'h0);
    run_req(1'b1, 32'hFFFFFFFE, 32'h11223344, 2'b10, 1'b0, d, s, r, f);
`ifdef DMEM_MISALIGN_SPLIT_EN
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 32'hFFFFFFFC || log_be[0] !== 4'b1100 ||
        log_wd[0] !== 32'h33440000 || log_addr[1] !== 32'h0 || log_be[1] !== 4'b0011 ||
        log_wd[1] !== 32'h00001122) begin
      errors++; $display("FAIL wrap_sw: n %0d %h/%b/%h %h/%b/%h, expected fffffffc/1100/33440000 00000000/0011/00001122",
                         log_addr.size(), log_addr[0], log_be[0], log_wd[0], log_addr[1], log_be[1], log_wd[1]);
    end
    checks++;
    if (d != 5 || rsp_rdata !== 32'h44332211) begin
      errors++; $display("FAIL wrap_done: done %0d rdata %h, expected 5 44332211", d, rsp_rdata);
    end
`else
    checks++;
    if (d != 1 || f !== 1'b1 || log_addr.size() != 0) begin
      errors++; $display("FAIL wrap_fault: done %0d fault %b beats %0d, expected 1 1 0", d, f, log_addr.size());
    end
    rdq.delete();
`endif
  endtask

  task automatic test_gnt_delay;
    int done_cyc = -1;
    int stalls = 0;
    int unstable = 0;
    clear_log(); gnt_delay = 3; rdq.push_back(32'h12345678);
    req_we = 1'b0; req_addr = 32'h500; req_wdata = 32'hCAFEF00D; req_size = 2'b10; req_signed = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (mem_req && (mem_addr !== 32'h500 || mem_be !== 4'b1111 || mem_we !== 1'b0 ||
                      mem_wdata !== 32'hCAFEF00D)) unstable++;
      if (rsp_valid) begin done_cyc = c; break; end
      tick();
    end
    tick();
    req_valid = 1'b0;
    gnt_delay = 0;
    checks++;
    if (done_cyc != 6 || stalls != 6) begin
      errors++; $display("FAIL gnt_delay_timing: done %0d stalls %0d, expected 6 6", done_cyc, stalls);
    end
    checks++;
    if (unstable != 0 || rsp_rdata !== 32'h12345678) begin
      errors++; $display("FAIL gnt_delay_hold: unstable cycles %0d rdata %h, expected 0 12345678", unstable, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid;
    int stray = 0;
    mem_auto = 1'b0;
    req_we = 1'b0; req_addr = 32'h600; req_size = 2'b10; req_signed = 1'b0; req_valid = 1'b1;
    tick();
    man_gnt = 1'b1;           // cycle 1: REQ0 granted at once
    tick();
    man_gnt = 1'b0;           // cycle 2: RSP0
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || mem_addr !== 32'h600) begin
      errors++; $display("FAIL rsp0_reach: stall %b addr %h, expected 1 00000600", stall, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, rsp_valid, misalign_fault, mem_req, mem_we} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_be !== 4'h0 || mem_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid: ctrl %b addr %h be %b wdata %h rdata %h, expected all zero",
                         {stall, rsp_valid, misalign_fault, mem_req, mem_we}, mem_addr, mem_be, mem_wdata, rsp_rdata);
    end
    tick();
    rst_n = 1'b1; req_valid = 1'b0;
    man_rvalid = 1'b1; man_rdata = 32'hBADBAD00;
    tick();
    man_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid || stall || mem_req) stray++;
    end
    checks++;
    if (stray != 0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL stray_rvalid: %0d active cycles rdata %h, expected 0 00000000", stray, rsp_rdata);
    end
    tick();
    mem_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_lh();
    test_split();
    test_wrap();
    test_gnt_delay();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
